fetch_align_buffer: RTL

- Sits between instruction memory and the decompress/decode stage.
- Takes word-aligned 32-bit fetch data and splits it into 16-bit parcels held in a small queue.
- Presents one instruction per handshake: either a compressed instruction zero-extended to 32 bits, or a full 32-bit instruction that may straddle two fetch words.
- Tracks the PC of every instruction and handles redirects, including targets at PC[1]=1.

---
 rtl/fetch_align_pkg.sv | 19 +
 rtl/parcel_fifo.sv | 74 +++++++
 rtl/fetch_align_buffer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fetch_align_pkg.sv
// Shared types and helpers for the fetch alignment buffer: FSM states,
// parcel width and the compressed-instruction test.
package fetch_align_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fa_state_e;

  localparam int PARCEL_W = 16;
  localparam logic [1:0] RVC_FULL_OP = 2'b11;

  // A parcel opens a 32-bit instruction only when its two low bits are 2'b11.
  function automatic logic is_compressed(input logic [PARCEL_W-1:0] parcel);
    return parcel[1:0] != RVC_FULL_OP;
  endfunction

endpackage

// File: rtl/parcel_fifo.sv
// Circular buffer of 16-bit parcels: push 0/1/2, pop 0/1/2, flush.
// Exposes the two oldest parcels and the occupancy count.
module parcel_fifo
  import fetch_align_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [1:0]                   push_n_i,
  input  logic [2*PARCEL_W-1:0]        push_data_i,
  input  logic [1:0]                   pop_n_i,
  output logic [PARCEL_W-1:0]          head0_o,
  output logic [PARCEL_W-1:0]          head1_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PARCEL_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_p1, wr_ptr_p1;
  logic [CW-1:0]       count_q, count_d;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [1:0] n);
    logic [PW:0] sum;
    sum = {1'b0, ptr} + (PW+1)'(n);
    if (sum >= (PW+1)'(DEPTH)) sum = sum - (PW+1)'(DEPTH);
    return sum[PW-1:0];
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    rd_ptr_p1 = ptr_add(rd_ptr_q, 2'd1);
    wr_ptr_p1 = ptr_add(wr_ptr_q, 2'd1);
    head0_o   = mem_q[rd_ptr_q];
    head1_o   = mem_q[rd_ptr_p1];
    count_o   = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = ptr_add(rd_ptr_q, pop_n_i);
      wr_ptr_d = ptr_add(wr_ptr_q, push_n_i);
      count_d  = count_q + CW'(push_n_i) - CW'(pop_n_i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; entries are only read once count covers them.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (push_n_i != 2'd0) mem_q[wr_ptr_q]  <= push_data_i[PARCEL_W-1:0];
      if (push_n_i == 2'd2) mem_q[wr_ptr_p1] <= push_data_i[2*PARCEL_W-1:PARCEL_W];
    end
  end

endmodule

// File: rtl/fetch_align_buffer.sv
// Splits word-aligned fetch data into parcels and presents one instruction per
// handshake with its PC. Optional counters enabled by FETCH_ALIGN_STATS_EN.
module fetch_align_buffer
  import fetch_align_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_c_o
`ifdef FETCH_ALIGN_STATS_EN
  ,
  output logic [31:0] stat_c_cnt_o,
  output logic [31:0] stat_full_cnt_o
`endif
);

  localparam int            CW        = $clog2(DEPTH+1);
  localparam logic [CW-1:0] REQ_LIMIT = CW'(DEPTH - 2);

  fa_state_e           state_q, state_d;
  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic [31:0]         pc_q, pc_d;
  logic                discard_low_q, discard_low_d;
  logic                req_q, req_d;

  logic [PARCEL_W-1:0] head0, head1;
  logic [CW-1:0]       count, count_after;
  logic [1:0]          push_n, pop_n;
  logic [31:0]         push_data;
  logic                flush, head_is_c, avail, fire;

  parcel_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .push_n_i    (push_n),
    .push_data_i (push_data),
    .pop_n_i     (pop_n),
    .head0_o     (head0),
    .head1_o     (head1),
    .count_o     (count)
  );

  // Output side: data is a pure function of the queue head, so it holds while stalled.
  always_comb begin
    head_is_c     = is_compressed(head0);
    avail         = ((count != '0) && head_is_c) || (count >= CW'(2));
    instr_valid_o = avail && !redirect_valid_i;
    fire          = instr_valid_o && instr_ready_i;
    pop_n         = fire ? (head_is_c ? 2'd1 : 2'd2) : 2'd0;
    instr_o       = '0;
    if (avail) instr_o = head_is_c ? {16'h0000, head0} : {head1, head0};
    instr_is_c_o  = avail && head_is_c;
    instr_pc_o    = pc_q;
    mem_req_o     = req_q && !redirect_valid_i;
    mem_addr_o    = fetch_pc_q;
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    discard_low_d = discard_low_q;
    push_n        = 2'd0;
    push_data     = mem_rdata_i;
    flush         = 1'b0;

    case (state_q)
      IDLE: if (mem_req_o && mem_gnt_i) state_d = WAIT;
      WAIT: begin
        if (mem_rvalid_i) begin
          if (discard_low_q) begin
            push_n    = 2'd1;
            push_data = {16'h0000, mem_rdata_i[31:16]};
          end else begin
            push_n = 2'd2;
          end
          fetch_pc_d    = fetch_pc_q + 32'd4;
          discard_low_d = 1'b0;
          state_d       = IDLE;
        end
      end
      DROP:    if (mem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fire) pc_d = pc_q + (head_is_c ? 32'd2 : 32'd4);

    // A redirect overrides push and pop; a response arriving in the same
    // cycle is consumed and dropped, so nothing is left outstanding.
    if (redirect_valid_i) begin
      flush         = 1'b1;
      push_n        = 2'd0;
      pc_d          = redirect_pc_i;
      fetch_pc_d    = {redirect_pc_i[31:2], 2'b00};
      discard_low_d = redirect_pc_i[1];
      state_d       = (state_q == IDLE || mem_rvalid_i) ? IDLE : DROP;
    end

    // Request decision is registered from the next queue occupancy.
    count_after = flush ? '0 : count + CW'(push_n) - CW'(pop_n);
    req_d       = (state_d == IDLE) && (count_after <= REQ_LIMIT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
      pc_q          <= RESET_PC;
      discard_low_q <= 1'b0;
      req_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      discard_low_q <= discard_low_d;
      req_q         <= req_d;
    end
  end

`ifdef FETCH_ALIGN_STATS_EN
  logic [31:0] stat_c_cnt_q, stat_full_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_c_cnt_q    <= '0;
      stat_full_cnt_q <= '0;
    end else if (fire) begin
      if (head_is_c) stat_c_cnt_q    <= stat_c_cnt_q + 32'd1;
      else           stat_full_cnt_q <= stat_full_cnt_q + 32'd1;
    end
  end

  assign stat_c_cnt_o    = stat_c_cnt_q;
  assign stat_full_cnt_o = stat_full_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
